pixel_array_ctrl: RTL and testbench

Parametrised frame sequencer for an N-pixel array of PIXEL_SENSOR instances. It drives the shared erase/expose/convert/read control lines and the ramp-count onto the array data bus. It then reads each pixel in turn and streams the results out over a valid/ready handshake. It sits between the pixel array and the downstream frame buffer, and adds runtime exposure length, continuous mode and backpressure.

---
 rtl/pixel_array_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pixel_array_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a pixel sensor array: erase, expose, ramp conversion,
// then per-pixel readout streamed over a valid/ready handshake.
module pixel_array_ctrl #(
    parameter int NUM_PIXELS      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int ERASE_CYCLES    = 5,
    parameter int EXP_WIDTH       = 16,
    parameter int FRAME_CNT_WIDTH = 16,
    localparam int IDX_W          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cont_mode,
    input  logic [EXP_WIDTH-1:0]       expose_len,
    output logic                       pix_reset,
    output logic                       pix_erase,
    output logic                       pix_expose,
    output logic                       pix_ramp,
    output logic [NUM_PIXELS-1:0]      pix_read,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       data_oe,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       frame_done,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

    localparam int ECW   = $clog2(ERASE_CYCLES + 1);
    localparam int CNT_W = (EXP_WIDTH > ECW) ? EXP_WIDTH : ECW;

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_RD_SEL, S_RD_CAP, S_RD_OUT, S_DONE
    } state_t;

    state_t               state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [EXP_WIDTH-1:0] exp_len_r;
    logic [IDX_W-1:0]     idx_r;

    logic [EXP_WIDTH-1:0] len_s;
    logic [CNT_W-1:0]     exp_load_s;
    logic [IDX_W-1:0]     idx_next_s;
    logic                 last_idx_s;

    // A zero exposure request still exposes for one cycle
    function automatic logic [EXP_WIDTH-1:0] clamp_len(input logic [EXP_WIDTH-1:0] len);
        return (len == '0) ? EXP_WIDTH'(1) : len;
    endfunction

    assign len_s      = clamp_len(expose_len);
    assign exp_load_s = CNT_W'(exp_len_r) - CNT_W'(1);
    assign idx_next_s = idx_r + IDX_W'(1);
    assign last_idx_s = (idx_r == IDX_W'(NUM_PIXELS - 1));

    // Frame FSM; every output is set on the edge that enters its phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            exp_len_r   <= '0;
            idx_r       <= '0;
            pix_reset   <= 1'b0;
            pix_erase   <= 1'b0;
            pix_expose  <= 1'b0;
            pix_ramp    <= 1'b0;
            pix_read    <= '0;
            data_o      <= '0;
            data_oe     <= 1'b0;
            out_data    <= '0;
            out_index   <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else if (abort) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            idx_r      <= '0;
            pix_reset  <= 1'b0;
            pix_erase  <= 1'b0;
            pix_expose <= 1'b0;
            pix_ramp   <= 1'b0;
            pix_read   <= '0;
            data_o     <= '0;
            data_oe    <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r   <= S_ERASE;
                        busy      <= 1'b1;
                        pix_reset <= 1'b1;
                        pix_erase <= 1'b1;
                        cnt_r     <= CNT_W'(ERASE_CYCLES - 1);
                        exp_len_r <= len_s;
                    end
                end
                S_ERASE: begin
                    if (cnt_r == '0) begin
                        state_r    <= S_EXPOSE;
                        pix_reset  <= 1'b0;
                        pix_erase  <= 1'b0;
                        pix_expose <= 1'b1;
                        cnt_r      <= exp_load_s;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                S_EXPOSE: begin
                    if (cnt_r == '0) begin
                        state_r    <= S_CONVERT;
                        pix_expose <= 1'b0;
                        pix_ramp   <= 1'b1;
                        data_oe    <= 1'b1;
                        data_o     <= '0;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                S_CONVERT: begin
                    if (data_o == '1) begin
                        state_r  <= S_RD_SEL;
                        pix_ramp <= 1'b0;
                        data_oe  <= 1'b0;
                        data_o   <= '0;
                        idx_r    <= '0;
                        pix_read <= NUM_PIXELS'(1);
                    end else begin
                        data_o <= data_o + DATA_WIDTH'(1);
                    end
                end
                S_RD_SEL: begin
                    state_r <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    state_r   <= S_RD_OUT;
                    out_data  <= data_i;
                    out_index <= idx_r;
                    out_valid <= 1'b1;
                    pix_read  <= '0;
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_idx_s) begin
                            state_r     <= S_DONE;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
                        end else begin
                            state_r  <= S_RD_SEL;
                            idx_r    <= idx_next_s;
                            pix_read <= NUM_PIXELS'(1) << idx_next_s;
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    if (cont_mode) begin
                        state_r   <= S_ERASE;
                        pix_reset <= 1'b1;
                        pix_erase <= 1'b1;
                        cnt_r     <= CNT_W'(ERASE_CYCLES - 1);
                        exp_len_r <= len_s;
                    end else begin
                        state_r <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed bench for pixel_array_ctrl: a 4-pixel instance for timing, readout,
// backpressure, abort and reset, plus a tiny instance for frame counter wrap.
module tb_pixel_array_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0, abort = 1'b0, cont_mode = 1'b0;
    logic [15:0] expose_len = 16'd10;
    logic        pix_reset, pix_erase, pix_expose, pix_ramp;
    logic [3:0]  pix_read;
    logic [7:0]  data_o, data_i, out_data;
    logic        data_oe, out_valid, busy, frame_done;
    logic        out_ready = 1'b1;
    logic [1:0]  out_index;
    logic [15:0] frame_count;

    logic        start_b = 1'b0, cont_b = 1'b0;
    logic        pix_reset_b, pix_erase_b, pix_expose_b, pix_ramp_b;
    logic [0:0]  pix_read_b, data_o_b, out_data_b, out_index_b;
    logic        data_oe_b, out_valid_b, busy_b, frame_done_b;
    logic [1:0]  frame_count_b;

    pixel_array_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cont_mode(cont_mode),
        .expose_len(expose_len), .pix_reset(pix_reset), .pix_erase(pix_erase),
        .pix_expose(pix_expose), .pix_ramp(pix_ramp), .pix_read(pix_read),
        .data_o(data_o), .data_oe(data_oe), .data_i(data_i), .out_data(out_data),
        .out_index(out_index), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    pixel_array_ctrl #(.NUM_PIXELS(1), .DATA_WIDTH(1), .ERASE_CYCLES(1),
                       .EXP_WIDTH(4), .FRAME_CNT_WIDTH(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(1'b0), .cont_mode(cont_b),
        .expose_len(4'd1), .pix_reset(pix_reset_b), .pix_erase(pix_erase_b),
        .pix_expose(pix_expose_b), .pix_ramp(pix_ramp_b), .pix_read(pix_read_b),
        .data_o(data_o_b), .data_oe(data_oe_b), .data_i(1'b1), .out_data(out_data_b),
        .out_index(out_index_b), .out_valid(out_valid_b), .out_ready(1'b1),
        .busy(busy_b), .frame_done(frame_done_b), .frame_count(frame_count_b)
    );

    always #5 clk = ~clk;

    // Pixel bus model: the selected pixel drives 0x32 + 0x10*i
    always_comb begin
        data_i = 8'h00;
        for (int i = 0; i < 4; i++)
            if (pix_read[i]) data_i = 8'h32 + 8'(16 * i);
    end

    logic [7:0] exp_pix [4] = '{8'h32, 8'h42, 8'h52, 8'h62};

    int n_checks = 0, n_errors = 0;
    int overlap = 0, viol = 0;

    // Bus contention and phase exclusivity watcher
    always @(negedge clk) begin
        if (reset) begin
            if (data_oe && (|pix_read)) overlap++;
            if ($countones(pix_read) > 1) viol++;
            if ($countones({pix_erase, pix_expose, pix_ramp, |pix_read}) > 1) viol++;
            if (pix_reset && !pix_erase) viol++;
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int n_erase, n_expose, n_ramp, first_valid, frame_len, stalls, stall_bad, n_cap;
    logic [7:0] cap_data [8];
    logic [1:0] cap_idx  [8];

    task automatic run_frame(input int stall_pix, input int stall_len, input logic [15:0] mid_len);
        int off;
        bit done;
        n_erase = 0; n_expose = 0; n_ramp = 0; first_valid = -1; frame_len = 0;
        stalls = 0; stall_bad = 0; n_cap = 0; off = 0; done = 1'b0;
        out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!done && off < 2000) begin
            if (pix_erase) n_erase++;
            if (pix_ramp) n_ramp++;
            if (pix_expose) begin
                n_expose++;
                if (n_expose == 2 && mid_len != 16'd0) expose_len = mid_len;
            end
            if (out_valid && first_valid < 0) first_valid = off;
            if (out_valid && int'(out_index) == stall_pix && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
                if (out_data != exp_pix[stall_pix] || pix_read != 4'd0) stall_bad++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready && n_cap < 8) begin
                cap_data[n_cap] = out_data;
                cap_idx[n_cap]  = out_index;
                n_cap++;
            end
            if (frame_done) begin
                done = 1'b1;
                frame_len = off + 1;
            end
            @(negedge clk);
            off++;
        end
        out_ready = 1'b1;
        check_val("frame_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_readout(input string tag);
        check_val({tag, "_ncap"}, 64'(n_cap), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s_data%0d", tag, i), 64'(cap_data[i]), 64'(exp_pix[i]));
            check_val($sformatf("%s_idx%0d", tag, i), 64'(cap_idx[i]), 64'(i));
        end
    endtask

    initial begin
        int nd, idle, budget, fc3;

        // Reset held with start high, then released
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_outs", 64'({pix_reset, pix_erase, pix_expose, pix_ramp, pix_read, data_o,
                  data_oe, out_data, out_index, out_valid, busy, frame_done, frame_count}), 64'd0);
        start = 1'b0; reset = 1'b1;
        repeat (3) @(negedge clk);
        check_val("post_rst_outs", 64'({pix_reset, pix_erase, pix_expose, pix_ramp, pix_read, data_o,
                  data_oe, out_data, out_index, out_valid, busy, frame_done, frame_count}), 64'd0);

        // abort wins over start in IDLE
        start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check_val("abort_prio_busy", 64'(busy), 64'd0);

        // Nominal frame, expose_len = 10
        expose_len = 16'd10;
        run_frame(-1, 0, 16'd0);
        check_val("f1_erase", 64'(n_erase), 64'd5);
        check_val("f1_expose", 64'(n_expose), 64'd10);
        check_val("f1_ramp", 64'(n_ramp), 64'd256);
        check_val("f1_first_valid", 64'(first_valid), 64'd273);
        check_val("f1_len", 64'(frame_len), 64'd284);
        check_val("f1_count", 64'(frame_count), 64'd1);
        check_val("f1_busy_end", 64'(busy), 64'd0);
        check_readout("f1");

        // Backpressure: 7 stall cycles on pixel 2
        run_frame(2, 7, 16'd0);
        check_val("bp_stalls", 64'(stalls), 64'd7);
        check_val("bp_stable", 64'(stall_bad), 64'd0);
        check_val("bp_len", 64'(frame_len), 64'd291);
        check_val("bp_count", 64'(frame_count), 64'd2);
        check_readout("bp");

        // Zero exposure treated as one cycle
        expose_len = 16'd0;
        run_frame(-1, 0, 16'd0);
        check_val("e0_expose", 64'(n_expose), 64'd1);
        check_val("e0_len", 64'(frame_len), 64'd275);

        // Exposure length changed mid-EXPOSE has no effect
        expose_len = 16'd10;
        run_frame(-1, 0, 16'd40);
        check_val("mid_expose", 64'(n_expose), 64'd10);
        check_val("mid_count", 64'(frame_count), 64'd4);

        // Continuous mode: three back-to-back frames
        expose_len = 16'd1; cont_mode = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        nd = 0; idle = 0; budget = 0;
        while (nd < 3 && budget < 3000) begin
            if (!busy) idle++;
            if (frame_done) nd++;
            if (nd == 2 && !frame_done) cont_mode = 1'b0;
            @(negedge clk);
            budget++;
        end
        check_val("cont_frames", 64'(nd), 64'd3);
        check_val("cont_idle", 64'(idle), 64'd0);
        check_val("cont_count", 64'(frame_count), 64'd7);
        @(negedge clk);
        check_val("cont_stop_busy", 64'(busy), 64'd0);

        // Abort during conversion at data_o = 0x80
        expose_len = 16'd10;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = 0;
        while (!(pix_ramp && data_o == 8'h80) && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        check_val("abort_reach", 64'(data_o), 64'h80);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_oe", 64'({data_oe, pix_ramp}), 64'd0);
        check_val("abort_data_o", 64'(data_o), 64'd0);
        check_val("abort_count", 64'(frame_count), 64'd7);

        // Asynchronous reset while a pixel is held in RD_OUT
        out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        budget = 0;
        while (!out_valid && budget < 600) begin
            @(negedge clk);
            budget++;
        end
        check_val("rdout_reach", 64'(out_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        check_val("async_valid", 64'(out_valid), 64'd0);
        check_val("async_busy", 64'(busy), 64'd0);
        check_val("async_count", 64'(frame_count), 64'd0);
        @(negedge clk); reset = 1'b1; out_ready = 1'b1;

        // Small instance: 2-bit frame counter wraps after four frames
        cont_b = 1'b1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        nd = 0; budget = 0; fc3 = -1;
        while (nd < 4 && budget < 200) begin
            if (frame_done_b) begin
                nd++;
                if (nd == 3) fc3 = int'(frame_count_b);
                if (nd == 4) cont_b = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        check_val("wrap_frames", 64'(nd), 64'd4);
        check_val("wrap_fc3", 64'(fc3), 64'd3);
        check_val("wrap_fc0", 64'(frame_count_b), 64'd0);
        @(negedge clk);
        check_val("wrap_idle", 64'(busy_b), 64'd0);

        check_val("bus_overlap", 64'(overlap), 64'd0);
        check_val("phase_excl", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
